// File: rtl/mode_sequencer.sv
// Mode-select sequencer: steps through enabled modes on button edges.
// Optional auto-repeat while a button is held: define MODE_SEQ_AUTO_REPEAT_EN.
module mode_sequencer #(
    parameter int          NUM_MODES   = 3,
    parameter int          RESET_MODE  = 0,
    parameter logic [31:0] HOLD_CYCLES = 32'd50_000_000,
    localparam int         MW          = $clog2(NUM_MODES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 next_bt,
    input  logic                 prev_bt,
    input  logic [NUM_MODES-1:0] mode_en,
    output logic [MW-1:0]        mode_sel,
    output logic [NUM_MODES-1:0] mode_onehot,
    output logic                 mode_changed
);

    localparam logic [NUM_MODES-1:0] ONE = {{(NUM_MODES-1){1'b0}}, 1'b1};

    if (NUM_MODES < 2 || NUM_MODES > 16 || RESET_MODE < 0 ||
        RESET_MODE >= NUM_MODES || HOLD_CYCLES == 32'd0) begin : g_bad_param
        $error("mode_sequencer: illegal parameter combination");
    end

    typedef enum logic {
        ST_IDLE,
        ST_HELD
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_dir;
    logic                 w_dir_nxt;
    logic                 r_next_q;
    logic                 r_prev_q;
    logic [MW-1:0]        r_mode;
    logic [MW-1:0]        w_mode_nxt;
    logic [NUM_MODES-1:0] r_onehot;
    logic                 r_changed;

    logic                 w_next_edge;
    logic                 w_prev_edge;
    logic                 w_btn_ok;
    logic                 w_active_lvl;
    logic                 w_others;
    logic                 w_cur_en;
    logic                 w_reloc;
    logic                 w_step;
    logic                 w_step_up;
    logic [MW-1:0]        w_seek_up;
    logic [MW-1:0]        w_seek_dn;

`ifdef MODE_SEQ_AUTO_REPEAT_EN
    logic [31:0]          r_cnt;
    logic [31:0]          w_cnt_nxt;
`endif

    // Nearest enabled mode other than cur, searching up or down with wrap.
    function automatic logic [MW-1:0] f_seek(
        input logic [MW-1:0]        cur,
        input logic [NUM_MODES-1:0] en,
        input logic                 up
    );
        logic [MW-1:0] res;
        int            s;
        res = cur;
        for (int i = NUM_MODES - 1; i >= 1; i--) begin
            s = up ? int'(cur) + i : int'(cur) + NUM_MODES - i;
            if (s >= NUM_MODES) begin
                s = s - NUM_MODES;
            end
            if (en[s]) begin
                res = MW'(s);
            end
        end
        return res;
    endfunction

    assign w_next_edge  = next_bt & ~r_next_q;
    assign w_prev_edge  = prev_bt & ~r_prev_q;
    assign w_others     = |(mode_en & ~r_onehot);
    assign w_cur_en     = |(mode_en & r_onehot);
    assign w_reloc      = ~w_cur_en & w_others;
    assign w_btn_ok     = (w_next_edge ^ w_prev_edge) & ~w_reloc;
    assign w_active_lvl = r_dir ? next_bt : prev_bt;
    assign w_seek_up    = f_seek(r_mode, mode_en, 1'b1);
    assign w_seek_dn    = f_seek(r_mode, mode_en, 1'b0);

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_mode_nxt  = r_mode;
        w_step      = 1'b0;
        w_step_up   = 1'b0;
`ifdef MODE_SEQ_AUTO_REPEAT_EN
        w_cnt_nxt   = r_cnt;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_btn_ok) begin
                    w_state_nxt = ST_HELD;
                    w_dir_nxt   = w_next_edge;
                    w_step      = 1'b1;
                    w_step_up   = w_next_edge;
`ifdef MODE_SEQ_AUTO_REPEAT_EN
                    w_cnt_nxt   = 32'd0;
`endif
                end
            end
            ST_HELD: begin
                if (w_btn_ok) begin
                    w_dir_nxt   = w_next_edge;
                    w_step      = 1'b1;
                    w_step_up   = w_next_edge;
`ifdef MODE_SEQ_AUTO_REPEAT_EN
                    w_cnt_nxt   = 32'd0;
`endif
                end else if (!w_active_lvl) begin
                    w_state_nxt = ST_IDLE;
`ifdef MODE_SEQ_AUTO_REPEAT_EN
                    w_cnt_nxt   = 32'd0;
                end else if (r_cnt == HOLD_CYCLES - 32'd1) begin
                    w_cnt_nxt   = 32'd0;
                    w_step      = 1'b1;
                    w_step_up   = r_dir;
                end else begin
                    w_cnt_nxt   = r_cnt + 32'd1;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Relocation off a disabled mode overrides any button step.
        if (w_reloc) begin
            w_mode_nxt = w_seek_up;
        end else if (w_step && w_others) begin
            w_mode_nxt = w_step_up ? w_seek_up : w_seek_dn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_dir     <= 1'b1;
            r_next_q  <= 1'b1;
            r_prev_q  <= 1'b1;
            r_mode    <= MW'(RESET_MODE);
            r_onehot  <= ONE << RESET_MODE;
            r_changed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dir     <= w_dir_nxt;
            r_next_q  <= next_bt;
            r_prev_q  <= prev_bt;
            r_mode    <= w_mode_nxt;
            r_onehot  <= ONE << w_mode_nxt;
            r_changed <= (w_mode_nxt != r_mode);
        end
    end

`ifdef MODE_SEQ_AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 32'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`endif

    assign mode_sel     = r_mode;
    assign mode_onehot  = r_onehot;
    assign mode_changed = r_changed;

endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

- Parametrised mode-select sequencer for the display/ADC datapath.
- Steps through `NUM_MODES` modes in either direction on debounced push-button rising edges, skipping modes masked off at run time.
- Drives a binary `mode_sel` and a one-hot `mode_onehot` to the output muxes, plus a one-cycle `mode_changed` strobe for downstream reload logic.
- Optional auto-repeat while a button is held.

## Interface
Parameters:
- `NUM_MODES`, 3: number of modes, 2..16.
- `RESET_MODE`, 0: mode index loaded on reset; must be < `NUM_MODES`.
- `HOLD_CYCLES`, 50_000_000: hold time before auto-repeat starts, and the repeat period; 32-bit; used only with `MODE_SEQ_AUTO_REPEAT_EN`.
- `MW` (localparam): `$clog2(NUM_MODES)`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `next_bt`  in  1  advance request; level, already debounced and synchronised to `clk`.
- `prev_bt`  in  1  step-back request; level, debounced and synchronised.
- `mode_en`  in  NUM_MODES  per-mode enable mask; bit i = 1 allows mode i.
- `mode_sel`  out  MW  current mode index, registered.
- `mode_onehot`  out  NUM_MODES  one-hot of `mode_sel`, registered.
- `mode_changed`  out  1  one-cycle pulse when `mode_sel` changes.

## Operation
- Edge detect:
  - `next_bt` and `prev_bt` each have a delay flop; reset value 1.
  - A button already held during reset therefore does not fire after reset release.
  - Edge = `bt & ~bt_q`.
- Step search:
  - On a next edge, the new mode is the first enabled index after the current one, ascending, wrapping `NUM_MODES-1`→0.
  - On a prev edge, the search descends, wrapping 0→`NUM_MODES-1`.
  - The search covers at most `NUM_MODES-1` candidates.
  - If no other mode is enabled, the mode holds and `mode_changed` stays 0.
- Simultaneous next and prev edges in the same cycle: both are dropped.
- Forced relocation:
  - If `mode_en[mode_sel]` = 0 and some other mode is enabled, the block moves to the next enabled mode in ascending order.
  - This takes priority over, and discards, any button edge in the same cycle.
- `mode_en` all zero: the mode holds and buttons are ignored.
- Control FSM (per block, driven by whichever button is active):
  - IDLE: on a valid edge, step and go to HELD.
  - HELD: when the button is released, go to IDLE.
  - Other button's edge while in HELD: steps normally and retargets the hold counter to that button.
- Reset values: `mode_sel`=`RESET_MODE`, `mode_onehot`=1<<`RESET_MODE`, `mode_changed`=0, FSM=IDLE, hold counter=0.
- Reset applies even if `mode_en[RESET_MODE]`=0. Forced relocation then occurs on the first cycle after reset release.

## Timing
- Latency:
  - A button sampled low at posedge k-1 and high at posedge k updates `mode_sel`/`mode_onehot` at posedge k.
  - `mode_changed` is high for the one cycle following posedge k, aligned with the new value.
- Forced relocation: `mode_sel` updates at the first posedge where the current mode's enable bit is sampled 0.
- Maximum stepping rate: one step per button edge; minimum two cycles between edges (low then high).
- `mode_sel` and `mode_onehot` never disagree in any cycle.
- Reset asserted mid-hold: counter and FSM clear at that edge; no step is produced.

## Configuration
- `MODE_SEQ_AUTO_REPEAT_EN` defined:
  - In HELD, a 32-bit counter increments while the active button stays high.
  - On reaching `HOLD_CYCLES`, the block performs one further step in that button's direction, pulses `mode_changed`, and reloads the counter to 0.
  - This repeats every `HOLD_CYCLES` cycles until release.
  - Release clears the counter.
- Not defined:
  - No counter is instantiated.
  - HELD only waits for release; exactly one step per press.

## Test plan
- Reset with `NUM_MODES`=3, `RESET_MODE`=0, `mode_en`=3'b111; three `next_bt` pulses → `mode_sel` 1, 2, 0; one `mode_changed` per pulse; `mode_onehot` 010, 100, 001.
- `mode_en`=3'b101, mode 0; `next_bt` → mode 2. `prev_bt` → mode 0. Then `mode_en`=3'b001 and `next_bt` → mode holds, no pulse.
- Mode 1, then clear `mode_en[1]` → mode 2 at the next posedge with one pulse. Asserting `next_bt` in that same cycle yields no extra step.
- `next_bt` and `prev_bt` rise in the same cycle → no change. Holding `next_bt` across reset release → no step.
- With the macro, `HOLD_CYCLES`=10: hold `next_bt` 35 cycles from mode 0 → steps at cycles 0, 10, 20, 30 → `mode_sel` 1, 2, 0, 1. Without the macro → a single step to 1.
